rx_fifo_ctrl: RTL and testbench
===============================

// Module: rx_fifo_ctrl
// PURPOSE
//  Downstream consumer of the UART receive block. Drains each received byte on data_ready and acks with a one-cycle data_read.
//  Stores {framing_error, byte} in a DEPTH-entry FIFO and presents entries to the system side over a valid/ready interface.
//  Decouples bus latency from serial arrival so the receive buffer's overrun_error stays low under bursty reads.
// PARAMETERS
//  DEPTH   8   FIFO entries; power of two, 2..256
//  AW      $clog2(DEPTH)   pointer width (derived, localparam)
// PORTS
//  clk            in   1   system clock, all logic on rising edge
//  n_rst          in   1   synchronous active-low reset
//  rx_data        in   8   received byte from the receive block
//  data_ready     in   1   receive block holds a valid byte
//  framing_error  in   1   stop-bit error for the held byte
//  overrun_error  in   1   receive block dropped a byte
//  data_read      out  1   one-cycle ack that pops the receive buffer
//  m_data         out  8   head byte
//  m_ferr         out  1   head byte had a framing error
//  m_valid        out  1   FIFO non-empty
//  m_ready        in   1   consumer accepts head when m_valid=1
//  count          out  AW+1 current occupancy, 0..DEPTH
//  full           out  1   count==DEPTH
//  ovr_sticky     out  1   overrun seen since reset or clr_ovr
//  clr_ovr        in   1   clears ovr_sticky
// BEHAVIOUR
//  - Reset (n_rst=0 at an edge):
//    - FSM returns to IDLE, pointers and count clear to 0.
//    - data_read=0, m_valid=0, full=0, ovr_sticky=0.
//    - m_data/m_ferr are don't-care while m_valid=0.
//    - Reset mid-transfer discards the pending byte; no data_read is issued.
//  - Ingress FSM states:
//    - IDLE: if data_ready && !full, go to ACK. If data_ready && full, stay in IDLE and hold; the byte waits in the receive buffer.
//    - ACK: for one cycle, write {framing_error, rx_data} at wr_ptr, increment wr_ptr, assert data_read=1. Go to SETTLE.
//    - SETTLE: one cycle with data_read=0 while the receive block deasserts data_ready. Go to IDLE.
//    - Every accepted byte produces exactly one data_read pulse. Minimum spacing is 3 cycles per byte.
//  - Egress:
//    - First-word fall-through: m_data/m_ferr always reflect mem[rd_ptr].
//    - A pop occurs on m_valid && m_ready and increments rd_ptr. m_ready while empty is ignored.
//  - Occupancy: count += push - pop. A simultaneous push and pop leaves count unchanged.
//    - Push when full cannot occur because ACK is gated by !full.
//    - Pointers wrap modulo DEPTH. count, not the pointers, distinguishes full from empty.
//  - Latency: a byte whose data_ready rises at cycle t is written in cycle t+1. m_valid is 1 by cycle t+2 when the FIFO was empty.
//  - ovr_sticky:
//    - Set on any cycle with overrun_error=1.
//    - clr_ovr clears it; if set and clear coincide, set wins.
// CONFIGURATION
//  RX_ERR_CNT_EN defined:
//    - Adds 8-bit outputs ferr_cnt and ovr_cnt. ferr_cnt counts bytes accepted with framing_error=1.
//    - ovr_cnt counts rising edges of overrun_error.
//    - Both counters saturate at 255 and clear on reset or clr_ovr.
//  RX_ERR_CNT_EN undefined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - Package uart_rx_pkg:
//    - typedef rx_entry_t = struct packed {logic ferr; logic [7:0] data;}.
//    - typedef enum rx_ing_state_t {IDLE, ACK, SETTLE}.
//  - Sub-module rx_fifo_mem: DEPTH x rx_entry_t register array, with a write port and a combinational read port.
//  - The FSM, pointers and flags live in rx_fifo_ctrl.
// TESTING
//  1. Single byte: data_ready=1, rx_data=8'hA5, m_ready=0.
//     -> data_read pulses once at t+1; m_valid=1, m_data=A5, m_ferr=0, count=1.
//  2. Fill: DEPTH bytes 00..07 presented back-to-back with m_ready=0.
//     -> full=1 and count=8. A 9th byte gets no data_read until one pop.
//     -> Then 00..07 drain in order, followed by the 9th byte.
//  3. Framing: byte 8'h3C with framing_error=1.
//     -> m_ferr=1 with m_data=3C. With RX_ERR_CNT_EN, ferr_cnt=1.
//  4. Simultaneous push/pop at count=3 -> count stays 3; order is preserved across pointer wrap after 20 such cycles.
//  5. Overrun pulse, then clr_ovr and overrun_error both high in the same cycle -> ovr_sticky stays 1. A later clr_ovr alone -> 0.
//  6. n_rst=0 during ACK with count=5 -> next cycle count=0, m_valid=0, data_read=0, FSM in IDLE.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive-side FIFO controller.
package uart_rx_pkg;

    localparam int unsigned RX_DATA_W = 8;

    typedef struct packed {
        logic                 ferr;
        logic [RX_DATA_W-1:0] data;
    } rx_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        SETTLE
    } rx_ing_state_t;

    // Saturating 8-bit increment for the error counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// DEPTH-entry register array for received entries, one write port and a
// combinational read port so the head falls through to the consumer.
module rx_fifo_mem
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  rx_entry_t       wdata,
    input  logic [AW-1:0]   raddr,
    output rx_entry_t       rdata
);

    rx_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rx_fifo_ctrl.sv
// Drains bytes from the UART receive buffer into a small FIFO and presents
// them over valid/ready. Optional error counters under RX_ERR_CNT_EN.
module rx_fifo_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [7:0]    rx_data,
    input  logic          data_ready,
    input  logic          framing_error,
    input  logic          overrun_error,
    output logic          data_read,
    output logic [7:0]    m_data,
    output logic          m_ferr,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          ovr_sticky,
    input  logic          clr_ovr
`ifdef RX_ERR_CNT_EN
    ,
    output logic [7:0]    ferr_cnt,
    output logic [7:0]    ovr_cnt
`endif
);

    rx_ing_state_t state_q, state_d;
    logic          data_read_q, data_read_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          m_valid_q, m_valid_d;
    logic          full_q, full_d;
    logic          ovr_sticky_q, ovr_sticky_d;
    logic          push, pop;
    rx_entry_t     wr_entry, rd_entry;

    // Ingress handshake: one data_read per byte, then a settle cycle.
    always_comb begin
        state_d     = state_q;
        data_read_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_ready && !full_q) begin
                    state_d     = ACK;
                    data_read_d = 1'b1;
                end
            end
            ACK:     state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pointer, occupancy and flag updates.
    always_comb begin
        push         = (state_q == ACK);
        pop          = m_valid_q && m_ready;
        wr_entry     = '{ferr: framing_error, data: rx_data};
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d      = count_q + CW'(push) - CW'(pop);
        m_valid_d    = (count_d != '0);
        full_d       = (count_d == CW'(DEPTH));
        ovr_sticky_d = overrun_error | (ovr_sticky_q & ~clr_ovr);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            data_read_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            m_valid_q    <= 1'b0;
            full_q       <= 1'b0;
            ovr_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_read_q  <= data_read_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            m_valid_q    <= m_valid_d;
            full_q       <= full_d;
            ovr_sticky_q <= ovr_sticky_d;
        end
    end

    rx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push && n_rst),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    assign data_read  = data_read_q;
    assign m_data     = rd_entry.data;
    assign m_ferr     = rd_entry.ferr;
    assign m_valid    = m_valid_q;
    assign count      = count_q;
    assign full       = full_q;
    assign ovr_sticky = ovr_sticky_q;

`ifdef RX_ERR_CNT_EN
    logic [7:0] ferr_cnt_q, ferr_cnt_d;
    logic [7:0] ovr_cnt_q, ovr_cnt_d;
    logic       ovr_prev_q;

    // Saturating error counters; clr_ovr takes priority over an increment.
    always_comb begin
        ferr_cnt_d = ferr_cnt_q;
        ovr_cnt_d  = ovr_cnt_q;
        if (clr_ovr) begin
            ferr_cnt_d = '0;
            ovr_cnt_d  = '0;
        end else begin
            if (push && framing_error)        ferr_cnt_d = sat_inc8(ferr_cnt_q);
            if (overrun_error && !ovr_prev_q) ovr_cnt_d  = sat_inc8(ovr_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            ferr_cnt_q <= '0;
            ovr_cnt_q  <= '0;
            ovr_prev_q <= 1'b0;
        end else begin
            ferr_cnt_q <= ferr_cnt_d;
            ovr_cnt_q  <= ovr_cnt_d;
            ovr_prev_q <= overrun_error;
        end
    end

    assign ferr_cnt = ferr_cnt_q;
    assign ovr_cnt  = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Directed bench for rx_fifo_ctrl; checks error counters when RX_ERR_CNT_EN is defined.
module tb_rx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       framing_error;
    logic       overrun_error;
    logic       data_read;
    logic [7:0] m_data;
    logic       m_ferr;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] count;
    logic       full;
    logic       ovr_sticky;
    logic       clr_ovr;
`ifdef RX_ERR_CNT_EN
    logic [7:0] ferr_cnt;
    logic [7:0] ovr_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rx_fifo_ctrl #(.DEPTH(8)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .data_read     (data_read),
        .m_data        (m_data),
        .m_ferr        (m_ferr),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .count         (count),
        .full          (full),
        .ovr_sticky    (ovr_sticky),
        .clr_ovr       (clr_ovr)
`ifdef RX_ERR_CNT_EN
        ,
        .ferr_cnt      (ferr_cnt),
        .ovr_cnt       (ovr_cnt)
`endif
    );

    // Stimulus only: waits (bounded) for data_read, then drops data_ready in SETTLE.
    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (data_read === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        data_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic f, output bit ok);
        rx_data       = d;
        framing_error = f;
        data_ready    = 1'b1;
        wait_ack(ok);
    endtask

    // Stimulus only: captures the head entry and pops it.
    task automatic pop_one(output logic [8:0] e);
        @(negedge clk);
        e       = {m_ferr, m_data};
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; rx_data = '0; data_ready = 1'b0; framing_error = 1'b0;
        overrun_error = 1'b0; m_ready = 1'b0; clr_ovr = 1'b0;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({data_read, m_valid, full, ovr_sticky, count} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: got dr/mv/full/ovr/count=%b%b%b%b/%0d required 0000/0",
                     data_read, m_valid, full, ovr_sticky, count);
        end
`ifdef RX_ERR_CNT_EN
        n_vec++;
        if ({ferr_cnt, ovr_cnt} !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_counters: got %0d/%0d required 0/0", ferr_cnt, ovr_cnt);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_single_byte();
        logic [8:0] e;
        rx_data = 8'hA5; framing_error = 1'b0; data_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (data_read !== 1'b0) begin
            n_err++; $display("FAIL single_dr_t: got %b required 0", data_read);
        end
        @(negedge clk);
        n_vec++;
        if (data_read !== 1'b1) begin
            n_err++; $display("FAIL single_dr_t1: got %b required 1", data_read);
        end
        @(posedge clk); #1 data_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({data_read, m_valid, m_ferr, m_data, count} !== {1'b0, 1'b1, 1'b0, 8'hA5, 4'd1}) begin
            n_err++;
            $display("FAIL single_head: got dr=%b mv=%b ferr=%b data=%h count=%0d required 0 1 0 a5 1",
                     data_read, m_valid, m_ferr, m_data, count);
        end
        @(posedge clk); #1;
        pop_one(e);
        @(negedge clk);
        n_vec++;
        if ({m_valid, count} !== 5'b0_0000) begin
            n_err++; $display("FAIL single_drain: got mv=%b count=%0d required 0 0", m_valid, count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        bit ok;
        bit seen;
        logic [8:0] e;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i), 1'b0, ok);
            n_vec++;
            if (!ok) begin
                n_err++; $display("FAIL fill_ack_%0d: got no data_read required one pulse", i);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({full, count} !== {1'b1, 4'd8}) begin
            n_err++; $display("FAIL fill_full: got full=%b count=%0d required 1 8", full, count);
        end
        @(posedge clk); #1;
        rx_data = 8'h08; framing_error = 1'b0; data_ready = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (data_read === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL fill_hold: got data_read while full required none");
        end
        @(posedge clk); #1;
        pop_one(e);
        n_vec++;
        if (e !== 9'h000) begin
            n_err++; $display("FAIL fill_pop_0: got %h required 000", e);
        end
        wait_ack(ok);
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL fill_ack_9th: got no data_read required one pulse after pop");
        end
        for (int i = 1; i <= 8; i++) begin
            pop_one(e);
            n_vec++;
            if (e !== 9'(i)) begin
                n_err++; $display("FAIL fill_order_%0d: got %h required %h", i, e, 9'(i));
            end
        end
        @(negedge clk);
        n_vec++;
        if ({m_valid, full, count} !== 6'b00_0000) begin
            n_err++; $display("FAIL fill_empty: got mv=%b full=%b count=%0d required 0 0 0", m_valid, full, count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_framing();
        bit ok;
        logic [8:0] e;
        send_byte(8'h3C, 1'b1, ok);
        @(negedge clk);
        n_vec++;
        if ({ok, m_valid, m_ferr, m_data} !== {1'b1, 1'b1, 1'b1, 8'h3C}) begin
            n_err++;
            $display("FAIL framing_head: got ok=%b mv=%b ferr=%b data=%h required 1 1 1 3c", ok, m_valid, m_ferr, m_data);
        end
`ifdef RX_ERR_CNT_EN
        n_vec++;
        if (ferr_cnt !== 8'd1) begin
            n_err++; $display("FAIL framing_cnt: got %0d required 1", ferr_cnt);
        end
`endif
        @(posedge clk); #1;
        framing_error = 1'b0;
        pop_one(e);
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [8:0] e;
        logic [8:0] q[$];
        bit timeout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h40 + 8'(i), 1'b0, ok);
            q.push_back({1'b0, 8'h40 + 8'(i)});
        end
        for (int k = 0; k < 20; k++) begin
            rx_data = 8'h50 + 8'(k); framing_error = k[0]; data_ready = 1'b1;
            ok = 1'b0;
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                if (data_read === 1'b1) begin ok = 1'b1; break; end
            end
            if (!ok) timeout = 1'b1;
            e = {m_ferr, m_data};
            m_ready = 1'b1;
            @(posedge clk); #1;
            m_ready = 1'b0; data_ready = 1'b0;
            q.push_back({k[0], 8'h50 + 8'(k)});
            n_vec++;
            if (e !== q[0]) begin
                n_err++; $display("FAIL b2b_order_%0d: got %h required %h", k, e, q[0]);
            end
            void'(q.pop_front());
            @(negedge clk);
            n_vec++;
            if (count !== 4'd3) begin
                n_err++; $display("FAIL b2b_count_%0d: got %0d required 3", k, count);
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (timeout) begin
            n_err++; $display("FAIL b2b_ack: got missing data_read required one per byte");
        end
        for (int i = 0; i < 3; i++) begin
            pop_one(e);
            n_vec++;
            if (e !== q[i]) begin
                n_err++; $display("FAIL b2b_drain_%0d: got %h required %h", i, e, q[i]);
            end
        end
        framing_error = 1'b0;
    endtask

    task automatic test_overrun();
        overrun_error = 1'b1;
        @(posedge clk); #1 overrun_error = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ovr_sticky !== 1'b1) begin
            n_err++; $display("FAIL ovr_set: got %b required 1", ovr_sticky);
        end
`ifdef RX_ERR_CNT_EN
        n_vec++;
        if (ovr_cnt !== 8'd1) begin
            n_err++; $display("FAIL ovr_cnt_1: got %0d required 1", ovr_cnt);
        end
`endif
        @(posedge clk); #1 overrun_error = 1'b1; clr_ovr = 1'b1;
        @(posedge clk); #1 overrun_error = 1'b0; clr_ovr = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ovr_sticky !== 1'b1) begin
            n_err++; $display("FAIL ovr_set_wins: got %b required 1", ovr_sticky);
        end
        @(posedge clk); #1 clr_ovr = 1'b1;
        @(posedge clk); #1 clr_ovr = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ovr_sticky !== 1'b0) begin
            n_err++; $display("FAIL ovr_clear: got %b required 0", ovr_sticky);
        end
`ifdef RX_ERR_CNT_EN
        n_vec++;
        if ({ferr_cnt, ovr_cnt} !== 16'h0000) begin
            n_err++; $display("FAIL cnt_clear: got %0d/%0d required 0/0", ferr_cnt, ovr_cnt);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_ack();
        bit ok;
        bit seen;
        for (int i = 0; i < 5; i++) send_byte(8'h60 + 8'(i), 1'b0, ok);
        rx_data = 8'h77; data_ready = 1'b1;
        ok = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (data_read === 1'b1) begin ok = 1'b1; break; end
        end
        n_vec++;
        if ({ok, count} !== {1'b1, 4'd5}) begin
            n_err++; $display("FAIL rst_ack_pre: got ack=%b count=%0d required 1 5", ok, count);
        end
        n_rst = 1'b0;
        @(posedge clk); #1 n_rst = 1'b1; data_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({count, m_valid, data_read, full} !== 7'b0000_000) begin
            n_err++;
            $display("FAIL rst_mid_ack: got count=%0d mv=%b dr=%b full=%b required 0 0 0 0", count, m_valid, data_read, full);
        end
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (data_read === 1'b1 || m_valid === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL rst_idle: got activity after reset required none");
        end
        @(posedge clk); #1;
        send_byte(8'h99, 1'b0, ok);
        @(negedge clk);
        n_vec++;
        if ({ok, count, m_data} !== {1'b1, 4'd1, 8'h99}) begin
            n_err++; $display("FAIL rst_recover: got ok=%b count=%0d data=%h required 1 1 99", ok, count, m_data);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill();
        test_framing();
        test_back_to_back();
        test_overrun();
        test_reset_mid_ack();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
